// File: rtl/wishbone_arbiter_if.sv
//------------------------------------------------------------------------------
// wishbone_arbiter_if
// Bundle of master-side and slave-side Wishbone classic signals for the arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface wishbone_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_data_i;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;
  logic [DATA_W-1:0]             m_data_o;
  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [ADDR_W-1:0]             s_addr_o;
  logic [DATA_W-1:0]             s_data_o;
  logic                          s_ack_i;
  logic [DATA_W-1:0]             s_data_i;
  logic [NUM_MASTERS-1:0]        grant_o;
  logic                          busy_o;

  // Arbiter view: serves the requesting masters and drives the shared slave.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_ack_i, s_data_i,
    output m_ack_o, m_err_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o,
    output s_data_o, grant_o, busy_o
  );

  // Environment view: the requesting masters plus the shared slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_ack_i, s_data_i,
    input  m_ack_o, m_err_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o,
    input  s_data_o, grant_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/wishbone_arbiter.sv
//------------------------------------------------------------------------------
// wishbone_arbiter
// Round-robin Wishbone classic arbiter with bus-cycle grant lock and ack watchdog.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module wishbone_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  wishbone_arbiter_if.slave  bus
);

  localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [c_IDX_W-1:0]     r_ptr;

  logic                   w_found;
  logic [c_IDX_W-1:0]     w_cand;
  logic [c_IDX_W-1:0]     w_next_idx;
  logic [NUM_MASTERS-1:0] w_next_oh;
  logic                   w_in_own;
  logic                   w_own_cyc;
  logic                   w_own_stb;
  logic                   w_own_we;
  logic [ADDR_W-1:0]      w_own_addr;
  logic [DATA_W-1:0]      w_own_data;
  logic                   w_expire;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    w_found    = 1'b0;
    w_cand     = '0;
    w_next_idx = r_ptr;
    w_next_oh  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = c_IDX_W'((int'(r_ptr) + i) % NUM_MASTERS);
      if (!w_found && bus.m_cyc_i[w_cand]) begin
        w_found           = 1'b1;
        w_next_idx        = w_cand;
        w_next_oh         = '0;
        w_next_oh[w_cand] = 1'b1;
      end
    end
  end

  // While busy the pointer doubles as the current owner's index.
  assign w_own_cyc  = bus.m_cyc_i[r_ptr];
  assign w_own_stb  = bus.m_stb_i[r_ptr];
  assign w_own_we   = bus.m_we_i[r_ptr];
  assign w_own_addr = bus.m_addr_i[r_ptr*ADDR_W +: ADDR_W];
  assign w_own_data = bus.m_data_i[r_ptr*DATA_W +: DATA_W];
  assign w_in_own   = (r_state == ST_OWN);

  assign bus.s_cyc_o  = w_in_own & w_own_cyc;
  assign bus.s_stb_o  = w_in_own & w_own_cyc & w_own_stb;
  assign bus.s_we_o   = w_in_own & w_own_we;
  assign bus.s_addr_o = w_in_own ? w_own_addr : '0;
  assign bus.s_data_o = w_in_own ? w_own_data : '0;

  // Late acks after an abort must never reach the master.
  assign bus.m_ack_o  = (w_in_own && bus.s_ack_i) ? r_grant : '0;
  assign bus.m_err_o  = (r_state == ST_ABORT) ? r_grant : '0;
  assign bus.m_data_o = bus.s_data_i;
  assign bus.grant_o  = r_grant;
  assign bus.busy_o   = (r_state != ST_IDLE);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      logic [15:0] r_wd;

      // Fires on the stalled cycle that would bring the count to the limit;
      // a same-cycle ack suppresses it.
      assign w_expire = w_in_own && bus.s_stb_o && !bus.s_ack_i &&
                        (r_wd == 16'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_wd <= '0;
        end else if (!w_in_own || !bus.s_stb_o || bus.s_ack_i || w_expire) begin
          r_wd <= '0;
        end else begin
          r_wd <= r_wd + 16'd1;
        end
      end
    end else begin : g_no_wdog
      assign w_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= c_IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_next_oh;
            r_ptr   <= w_next_idx;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!w_own_cyc) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!w_own_cyc) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
Round-robin arbiter that shares one Wishbone classic (non-pipelined) slave port between NUM_MASTERS requesters, e.g. the debug-transport wishbone_master and the CPU load/store unit. It locks the grant for the whole bus cycle (cyc held) and routes request, response and data paths by grant. A watchdog aborts cycles the slave never acknowledges and signals err to the owning master, so a dead slave cannot hang the debug path.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, cycles of stb without ack before abort (1..65535); 0 disables watchdog

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-low
m_cyc_i  in  NUM_MASTERS  per-master cycle request
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_addr_i  in  NUM_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
m_data_i  in  NUM_MASTERS*DATA_W  packed write data, same packing
m_ack_o  out  NUM_MASTERS  ack routed to granted master only
m_err_o  out  NUM_MASTERS  one-cycle timeout error to granted master
m_data_o  out  DATA_W  slave read data broadcast to all masters
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_addr_o  out  ADDR_W  slave address
s_data_o  out  DATA_W  slave write data
s_ack_i  in  1  slave acknowledge
s_data_i  in  DATA_W  slave read data
grant_o  out  NUM_MASTERS  one-hot registered grant (all-zero when idle)
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i=0, async): state IDLE, grant_o=0, last-grant pointer=NUM_MASTERS-1 (so master 0 wins first), watchdog=0; all outputs 0 except m_data_o which follows s_data_i.
- States: IDLE, OWN, ABORT, DRAIN.
- IDLE: if any m_cyc_i high, register grant to the first requester at index > last pointer, wrapping modulo NUM_MASTERS; update pointer; -> OWN. Grant visible one cycle after cyc rises (1-cycle arbitration latency). No request -> stay.
- OWN: s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o are combinational muxes of the granted master's inputs; m_ack_o[g]=s_ack_i, all other m_ack_o bits 0. Granted master keeps ownership across multiple stb phases while its cyc stays high (no preemption). Granted m_cyc_i low -> grant_o=0, -> IDLE; s_cyc_o/s_stb_o drop the same cycle (combinational). Re-arbitration happens from IDLE, so back-to-back owners have one idle cycle between them.
- Watchdog: 16-bit counter, cleared on entry to OWN and on every cycle s_ack_i=1 or s_stb_o=0; increments while s_stb_o=1 and s_ack_i=0. Reaching TIMEOUT_CYCLES -> ABORT. Disabled when TIMEOUT_CYCLES=0.
- ABORT (1 cycle): s_cyc_o=s_stb_o=0, m_err_o[g]=1, m_ack_o=0 -> DRAIN.
- DRAIN: slave outputs held 0, grant_o retained; wait for m_cyc_i[g]=0 -> grant_o=0, IDLE. Late s_ack_i in ABORT/DRAIN is ignored (never forwarded).
- Simultaneous: s_ack_i and watchdog terminal count in same cycle -> ack wins, counter clears, no error. Requests from non-granted masters are ignored until IDLE; their ack/err stay 0.
- Reset mid-cycle: all slave outputs and grant drop immediately (async); pointer restarts at NUM_MASTERS-1.

Test Plan:
- Single master: m_cyc_i=2'b01, stb, we=0, addr=0x1000; slave acks after 3 cycles with s_data_i=0xDEADBEEF -> grant_o=01 one cycle after request, m_ack_o=01 for one cycle, m_data_o=0xDEADBEEF, m_ack_o[1]=0 throughout.
- Contention: both cyc rise same cycle from reset -> master 0 granted; after it drops cyc, master 1 granted after one IDLE cycle; next simultaneous request grants master 0 (round-robin alternation over 4 rounds).
- Grant hold: master 1 owns and performs two write phases (addr 0x20, 0x24, data 0x11, 0x22) while master 0 requests -> master 0 never sees ack, s_addr_o never shows master 0 address until master 1 drops cyc.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> s_stb_o low on 5th cycle of strobe, m_err_o[g]=1 exactly one cycle, grant retained until m_cyc_i[g] low, then busy_o=0.
- Ack at terminal count: ack arrives on the 4th stalled cycle -> m_ack_o pulses, m_err_o stays 0.
- Async reset during OWN mid-stall -> s_cyc_o, grant_o, busy_o go 0 without a clock edge; after release, master 0 wins first arbitration.
